// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory-access stage:
// load/store size encodings, XLEN and FSM state constants.
package mem_stage_pkg;

   localparam int XLEN = 64;

   localparam logic [2:0] LB  = 3'b000;
   localparam logic [2:0] LH  = 3'b001;
   localparam logic [2:0] LW  = 3'b010;
   localparam logic [2:0] LD  = 3'b011;
   localparam logic [2:0] LBU = 3'b100;
   localparam logic [2:0] LHU = 3'b101;
   localparam logic [2:0] LWU = 3'b110;

   localparam logic [2:0] SB = 3'b000;
   localparam logic [2:0] SH = 3'b001;
   localparam logic [2:0] SW = 3'b010;
   localparam logic [2:0] SD = 3'b011;

   typedef logic [0:0] state_t;
   localparam state_t S_IDLE = 1'b0;
   localparam state_t S_RESP = 1'b1;

endpackage

// File: rtl/mem_lsu_fmt.sv
// Combinational load/store formatting: store lane shift and strobes,
// load lane extract with sign/zero extension, and alignment check.
module mem_lsu_fmt
   import mem_stage_pkg::*;
(
   input  logic            access_i,
   input  logic            is_load_i,
   input  logic [2:0]      offs_i,
   input  logic [2:0]      l_mux_i,
   input  logic [2:0]      s_mux_i,
   input  logic [XLEN-1:0] wdata_raw_i,
   input  logic [XLEN-1:0] rdata_i,
   output logic [XLEN-1:0] wdata_o,
   output logic [7:0]      wstrb_o,
   output logic [XLEN-1:0] load_o,
   output logic            misalign_o
);

   logic [1:0]      sz;
   logic            bad;
   logic [2:0]      amask;
   logic [7:0]      strb;
   logic [XLEN-1:0] lane;

   always_comb begin
      sz  = 2'd0;
      bad = 1'b0;
      if (is_load_i) begin
         unique case (l_mux_i)
            LB, LBU: sz = 2'd0;
            LH, LHU: sz = 2'd1;
            LW, LWU: sz = 2'd2;
            LD:      sz = 2'd3;
            default: bad = 1'b1;
         endcase
      end else begin
         unique case (s_mux_i)
            SB:      sz = 2'd0;
            SH:      sz = 2'd1;
            SW:      sz = 2'd2;
            SD:      sz = 2'd3;
            default: bad = 1'b1;
         endcase
      end
   end

   // size-1 as a low-bit mask; sz=3 wraps to 3'b111
   assign amask = (3'b001 << sz) - 3'd1;
   assign misalign_o = access_i & (bad | (|(offs_i & amask)));

   always_comb begin
      unique case (sz)
         2'd0:    strb = 8'h01;
         2'd1:    strb = 8'h03;
         2'd2:    strb = 8'h0F;
         default: strb = 8'hFF;
      endcase
   end

   assign wstrb_o = is_load_i ? 8'h00 : (strb << offs_i);
   assign wdata_o = wdata_raw_i << {offs_i, 3'b000};
   assign lane    = rdata_i >> {offs_i, 3'b000};

   always_comb begin
      unique case (l_mux_i)
         LB:      load_o = {{56{lane[7]}}, lane[7:0]};
         LH:      load_o = {{48{lane[15]}}, lane[15:0]};
         LW:      load_o = {{32{lane[31]}}, lane[31:0]};
         LD:      load_o = lane;
         LBU:     load_o = {56'd0, lane[7:0]};
         LHU:     load_o = {48'd0, lane[15:0]};
         LWU:     load_o = {32'd0, lane[31:0]};
         default: load_o = '0;
      endcase
   end

endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: data-memory req/gnt/rvalid handshake,
// stall generation and write-back value selection.
module mem_stage
   import mem_stage_pkg::*;
(
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic [XLEN-1:0] M_pc_i,
   input  logic [XLEN-1:0] M_alu_result_i,
   input  logic            M_reg_wen_i,
   input  logic            M_reg_mux_i,
   input  logic [4:0]      M_reg_waddr_i,
   input  logic            M_mem_wen_i,
   input  logic [XLEN-1:0] M_mem_wdata_temp_i,
   input  logic [XLEN-1:0] M_mem_addr_i,
   input  logic [2:0]      M_l_mux_i,
   input  logic [2:0]      M_s_mux_i,
   input  logic            M_adv_i,
   output logic            M_stall_o,
   output logic            M_misalign_o,
   output logic            dmem_req_o,
   output logic            dmem_we_o,
   output logic [XLEN-1:0] dmem_addr_o,
   output logic [XLEN-1:0] dmem_wdata_o,
   output logic [7:0]      dmem_wstrb_o,
   input  logic            dmem_gnt_i,
   input  logic            dmem_rvalid_i,
   input  logic [XLEN-1:0] dmem_rdata_i,
   output logic [XLEN-1:0] W_pc_o,
   output logic [XLEN-1:0] W_reg_wdata_o,
   output logic            W_reg_wen_o,
   output logic [4:0]      W_reg_waddr_o
);

   state_t          state_q, state_d;
   logic            served_q, served_d;
   logic [XLEN-1:0] rdata_q, rdata_d;

   logic            access, is_load, is_store, aligned;
   logic            req, done, resp_hit;
   logic [XLEN-1:0] fmt_wdata, load_val, rsel;
   logic [7:0]      fmt_wstrb;

   assign access   = M_reg_mux_i | M_mem_wen_i;
   assign is_load  = M_reg_mux_i;
   assign is_store = M_mem_wen_i & ~M_reg_mux_i;
   assign aligned  = ~M_misalign_o;
   assign resp_hit = (state_q == S_RESP) & dmem_rvalid_i;
   // a response only counts while one is outstanding
   assign rsel     = resp_hit ? dmem_rdata_i : rdata_q;

   mem_lsu_fmt u_fmt (
      .access_i    (access),
      .is_load_i   (is_load),
      .offs_i      (M_mem_addr_i[2:0]),
      .l_mux_i     (M_l_mux_i),
      .s_mux_i     (M_s_mux_i),
      .wdata_raw_i (M_mem_wdata_temp_i),
      .rdata_i     (rsel),
      .wdata_o     (fmt_wdata),
      .wstrb_o     (fmt_wstrb),
      .load_o      (load_val),
      .misalign_o  (M_misalign_o)
   );

   always_comb begin
      state_d = state_q;
      rdata_d = rdata_q;
      req     = 1'b0;
      done    = 1'b0;
      if (state_q == S_IDLE) begin
         req = access & aligned & ~served_q;
         if (req & dmem_gnt_i) begin
            if (is_load) state_d = S_RESP;
            else         done    = 1'b1;
         end
      end else if (dmem_rvalid_i) begin
         rdata_d = dmem_rdata_i;
         done    = 1'b1;
         state_d = S_IDLE;
      end
   end

   always_comb begin
      served_d = served_q;
      if (M_adv_i)   served_d = 1'b0;
      else if (done) served_d = 1'b1;
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q  <= S_IDLE;
         served_q <= 1'b0;
         rdata_q  <= '0;
      end else begin
         state_q  <= state_d;
         served_q <= served_d;
         rdata_q  <= rdata_d;
      end
   end

   assign M_stall_o    = access & aligned & ~served_q & ~done;
   assign dmem_req_o   = req;
   assign dmem_we_o    = req & is_store;
   assign dmem_addr_o  = req ? {M_mem_addr_i[XLEN-1:3], 3'b000} : '0;
   assign dmem_wdata_o = (req & is_store) ? fmt_wdata : '0;
   assign dmem_wstrb_o = (req & is_store) ? fmt_wstrb : 8'h00;

   assign W_pc_o        = M_pc_i;
   assign W_reg_waddr_o = M_reg_waddr_i;
   assign W_reg_wen_o   = M_reg_wen_i & ~M_misalign_o;
   assign W_reg_wdata_o = is_load ? load_val : M_alu_result_i;

endmodule

// File: tb/tb_mem_stage.sv
// Directed self-checking bench for mem_stage.
module tb_mem_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        rst;
   logic [63:0] pc, alu, wdt, addr, rdata;
   logic        reg_wen, reg_mux, mem_wen, adv, gnt, rvalid;
   logic [4:0]  waddr;
   logic [2:0]  lmux, smux;
   logic        stall, misal, req, we, W_wen;
   logic [63:0] d_addr, d_wdata, W_pc, W_wdata;
   logic [7:0]  wstrb;
   logic [4:0]  W_waddr;

   int checks = 0;
   int failures = 0;

   always #5 clk = ~clk;

   mem_stage dut (
      .clk_i(clk), .rst_i(rst),
      .M_pc_i(pc), .M_alu_result_i(alu),
      .M_reg_wen_i(reg_wen), .M_reg_mux_i(reg_mux),
      .M_reg_waddr_i(waddr), .M_mem_wen_i(mem_wen),
      .M_mem_wdata_temp_i(wdt), .M_mem_addr_i(addr),
      .M_l_mux_i(lmux), .M_s_mux_i(smux), .M_adv_i(adv),
      .M_stall_o(stall), .M_misalign_o(misal),
      .dmem_req_o(req), .dmem_we_o(we),
      .dmem_addr_o(d_addr), .dmem_wdata_o(d_wdata),
      .dmem_wstrb_o(wstrb), .dmem_gnt_i(gnt),
      .dmem_rvalid_i(rvalid), .dmem_rdata_i(rdata),
      .W_pc_o(W_pc), .W_reg_wdata_o(W_wdata),
      .W_reg_wen_o(W_wen), .W_reg_waddr_o(W_waddr)
   );

   task automatic clear_in();
      pc = '0; alu = '0; wdt = '0; addr = '0; rdata = '0;
      reg_wen = 0; reg_mux = 0; mem_wen = 0; adv = 0;
      gnt = 0; rvalid = 0; waddr = '0; lmux = '0; smux = '0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      clear_in();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL rst_req act=%b exp=0", req); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL rst_stall act=%b exp=0", stall); end
      checks++; if ({we, wstrb} !== 9'd0) begin failures++; $display("FAIL rst_we_strb act=%h exp=0", {we, wstrb}); end
      checks++; if ({d_addr, d_wdata} !== 128'd0) begin failures++; $display("FAIL rst_addr_wdata act=%h exp=0", {d_addr, d_wdata}); end
      checks++; if (misal !== 1'b0) begin failures++; $display("FAIL rst_misal act=%b exp=0", misal); end
      checks++; if (W_wdata !== 64'd0) begin failures++; $display("FAIL rst_wdata act=%h exp=0", W_wdata); end
   endtask

   task automatic test_passthru();
      clear_in();
      pc = 64'h0000_0000_8000_1234; alu = 64'hDEAD_BEEF_0000_0042;
      reg_wen = 1; waddr = 5'd17;
      #1;
      checks++; if (W_pc !== 64'h0000_0000_8000_1234) begin failures++; $display("FAIL pt_pc act=%h exp=0000000080001234", W_pc); end
      checks++; if (W_waddr !== 5'd17) begin failures++; $display("FAIL pt_waddr act=%0d exp=17", W_waddr); end
      checks++; if (W_wdata !== 64'hDEAD_BEEF_0000_0042) begin failures++; $display("FAIL pt_wdata act=%h exp=deadbeef00000042", W_wdata); end
      checks++; if (W_wen !== 1'b1) begin failures++; $display("FAIL pt_wen act=%b exp=1", W_wen); end
      checks++; if ({req, stall} !== 2'b00) begin failures++; $display("FAIL pt_req_stall act=%b exp=00", {req, stall}); end
      tick();
   endtask

   task automatic test_sb();
      clear_in();
      mem_wen = 1; smux = SB; addr = 64'h1003; wdt = 64'hAB;
      gnt = 1; adv = 1;
      #1;
      checks++; if ({req, we} !== 2'b11) begin failures++; $display("FAIL sb_req_we act=%b exp=11", {req, we}); end
      checks++; if (wstrb !== 8'h08) begin failures++; $display("FAIL sb_strb act=%h exp=08", wstrb); end
      checks++; if (d_wdata[31:24] !== 8'hAB) begin failures++; $display("FAIL sb_wdata act=%h exp=ab", d_wdata[31:24]); end
      checks++; if (d_addr !== 64'h1000) begin failures++; $display("FAIL sb_addr act=%h exp=1000", d_addr); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL sb_stall act=%b exp=0", stall); end
      tick();
   endtask

   task automatic test_lh();
      clear_in();
      reg_mux = 1; reg_wen = 1; lmux = LH; addr = 64'h2006; gnt = 1;
      #1;
      checks++; if ({req, we, wstrb} !== 10'b10_0000_0000) begin failures++; $display("FAIL lh_req act=%b exp=1000000000", {req, we, wstrb}); end
      checks++; if (stall !== 1'b1) begin failures++; $display("FAIL lh_stall0 act=%b exp=1", stall); end
      tick();
      gnt = 0; rvalid = 1; rdata = 64'h8001_0000_0000_0000; adv = 1;
      #1;
      checks++; if (req !== 1'b0) begin failures++; $display("FAIL lh_req1 act=%b exp=0", req); end
      checks++; if (stall !== 1'b0) begin failures++; $display("FAIL lh_stall1 act=%b exp=0", stall); end
      checks++; if (W_wdata !== 64'hFFFF_FFFF_FFFF_8001) begin failures++; $display("FAIL lh_data act=%h exp=ffffffffffff8001", W_wdata); end
      checks++; if (W_wen !== 1'b1) begin failures++; $display("FAIL lh_wen act=%b exp=1", W_wen); end
      tick();
   endtask

   task automatic test_lwu();
      clear_in();
      reg_mux = 1; reg_wen = 1; lmux = LWU; addr = 64'h2004; gnt = 1;
      tick();
      gnt = 0; rvalid = 1; rdata = 64'h8000_0001_0000_0000;
      #1;
      checks++; if (W_wdata !== 64'h0000_0000_8000_0001) begin failures++; $display("FAIL lwu_data act=%h exp=0000000080000001", W_wdata); end
      tick();
      // held by the pipe: value must come from the captured response
      rvalid = 0; rdata = '0;
      #1;
      checks++; if ({req, stall} !== 2'b00) begin failures++; $display("FAIL lwu_hold_req act=%b exp=00", {req, stall}); end
      checks++; if (W_wdata !== 64'h0000_0000_8000_0001) begin failures++; $display("FAIL lwu_hold_data act=%h exp=0000000080000001", W_wdata); end
      lmux = LW;
      #1;
      checks++; if (W_wdata !== 64'hFFFF_FFFF_8000_0001) begin failures++; $display("FAIL lw_sext act=%h exp=ffffffff80000001", W_wdata); end
      adv = 1;
      tick();
   endtask

   task automatic test_misalign();
      clear_in();
      reg_mux = 1; reg_wen = 1; lmux = LD; addr = 64'h3004; gnt = 1;
      #1;
      checks++; if (misal !== 1'b1) begin failures++; $display("FAIL ld_mis act=%b exp=1", misal); end
      checks++; if ({req, stall, W_wen} !== 3'b000) begin failures++; $display("FAIL ld_mis_req act=%b exp=000", {req, stall, W_wen}); end
      tick();
      clear_in();
      mem_wen = 1; smux = 3'b100; gnt = 1;
      #1;
      checks++; if ({misal, req, stall} !== 3'b100) begin failures++; $display("FAIL bad_smux act=%b exp=100", {misal, req, stall}); end
      tick();
   endtask

   task automatic test_gnt_wait();
      clear_in();
      mem_wen = 1; smux = SD; addr = 64'h4008;
      wdt = 64'h1122_3344_5566_7788;
      for (int i = 0; i < 3; i++) begin
         #1;
         checks++; if ({req, we, stall} !== 3'b111) begin failures++; $display("FAIL sd_wait%0d act=%b exp=111", i, {req, we, stall}); end
         checks++; if ({d_addr, d_wdata, wstrb} !== {64'h4008, 64'h1122_3344_5566_7788, 8'hFF}) begin failures++; $display("FAIL sd_fields%0d act=%h/%h/%h", i, d_addr, d_wdata, wstrb); end
         tick();
      end
      gnt = 1;
      #1;
      checks++; if ({req, stall} !== 2'b10) begin failures++; $display("FAIL sd_gnt act=%b exp=10", {req, stall}); end
      tick();
      for (int i = 0; i < 2; i++) begin
         #1;
         checks++; if ({req, stall} !== 2'b00) begin failures++; $display("FAIL sd_served%0d act=%b exp=00", i, {req, stall}); end
         tick();
      end
      adv = 1;
      tick();
      adv = 0; gnt = 0;
      #1;
      checks++; if ({req, stall} !== 2'b11) begin failures++; $display("FAIL sd_next act=%b exp=11", {req, stall}); end
      adv = 1; gnt = 1;
      tick();
   endtask

   task automatic test_reset_resp();
      clear_in();
      reg_mux = 1; reg_wen = 1; lmux = LD; addr = 64'h5000; gnt = 1;
      tick();
      gnt = 0;
      #1;
      checks++; if ({req, stall} !== 2'b01) begin failures++; $display("FAIL rr_resp act=%b exp=01", {req, stall}); end
      rst = 1;
      tick();
      rst = 0;
      clear_in();
      rvalid = 1; rdata = 64'hCAFE_F00D_1234_5678;
      #1;
      checks++; if ({req, we, stall, wstrb} !== 11'd0) begin failures++; $display("FAIL rr_out act=%b exp=0", {req, we, stall, wstrb}); end
      checks++; if ({d_addr, d_wdata, W_wdata} !== 192'd0) begin failures++; $display("FAIL rr_data act=%h exp=0", {d_addr, d_wdata, W_wdata}); end
      reg_mux = 1; lmux = LD; addr = 64'h5000;
      #1;
      checks++; if ({req, stall} !== 2'b11) begin failures++; $display("FAIL rr_idle act=%b exp=11", {req, stall}); end
      tick();
      #1;
      checks++; if ({req, stall} !== 2'b11) begin failures++; $display("FAIL rr_stale act=%b exp=11", {req, stall}); end
      clear_in();
      tick();
   endtask

   initial begin
      rst = 1'b1;
      clear_in();
      test_reset();
      test_passthru();
      test_sb();
      test_lh();
      test_lwu();
      test_misalign();
      test_gnt_wait();
      test_reset_resp();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
